// File: rtl/cluster_tx_scheduler_if.sv
// Bus bundle between the cluster packer side and the tx scheduler.
// master drives bx0/cluster_vld/clusters_in; slave (scheduler) drives the rest.
interface cluster_tx_scheduler_if;
    logic         bx0;
    logic         cluster_vld;
    logic [111:0] clusters_in;
    logic [1:0]   phase;
    logic [11:0]  bc;
    logic         locked;
    logic [27:0]  tx_data;
    logic         tx_valid;
    logic         tx_frame_start;
    logic [7:0]   sync_err_cnt;
    logic [7:0]   drop_cnt;

    modport master (
        output bx0, cluster_vld, clusters_in,
        input  phase, bc, locked, tx_data, tx_valid,
        input  tx_frame_start, sync_err_cnt, drop_cnt
    );

    modport slave (
        input  bx0, cluster_vld, clusters_in,
        output phase, bc, locked, tx_data, tx_valid,
        output tx_frame_start, sync_err_cnt, drop_cnt
    );
endinterface

// File: rtl/cluster_tx_scheduler.sv
// Cluster tx scheduler: bx0-aligned phase/bc counters, sync lock FSM and
// 4-word frame serialiser (2 clusters per clock4x word).
// Ports: clock4x, reset (async, active-low), bus (cluster_tx_scheduler_if.slave):
//   in  bx0, cluster_vld, clusters_in[111:0]
//   out phase[1:0], bc[11:0], locked, tx_data[27:0], tx_valid,
//       tx_frame_start, sync_err_cnt[7:0], drop_cnt[7:0]
// Optional: CLUSTER_TX_IDLE_SUPPRESS_EN drops tx_valid on all-empty words.
module cluster_tx_scheduler #(
    parameter int          MXBX        = 3564,
    parameter int          LOCK_CNT    = 2,
    parameter logic [10:0] INVALID_ADR = 11'h7FE
) (
    input logic                   clock4x,
    input logic                   reset,
    cluster_tx_scheduler_if.slave bus
);
    localparam logic [1:0] S_HUNT   = 2'd0;
    localparam logic [1:0] S_CHECK  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam int          LW      = $clog2(LOCK_CNT + 1);
    localparam logic [LW-1:0] LOCKN = LW'(LOCK_CNT);
    localparam logic [11:0] BC_LAST = 12'(MXBX - 1);

    logic [1:0]    state_q, state_d;
    logic [LW-1:0] lock_q, lock_d, lock_inc;
    logic [1:0]    phase_q, phase_d;
    logic [11:0]   bc_q, bc_d;
    logic          locked_q;
    logic [7:0]    serr_q, drop_q;
    logic          err_inc, load, slot;

    logic [83:0]   frame_q, frame_d;
    logic [1:0]    left_q, left_d;
    logic [27:0]   txd_q, txd_d;
    logic          txv_q, txv_d;
    logic          fs_q, fs_d;

`ifdef CLUSTER_TX_IDLE_SUPPRESS_EN
    function automatic logic idle_word(input logic [27:0] w);
        return (w[10:0] == INVALID_ADR) && (w[24:14] == INVALID_ADR);
    endfunction
`endif

    assign slot     = (phase_q == 2'd0) && (bc_q == 12'd0);
    assign lock_inc = lock_q + LW'(1);
    // Load decision uses pre-realign phase/state of this cycle.
    assign load     = bus.cluster_vld && (state_q == S_LOCKED) &&
                      (phase_q == 2'd3);

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        err_inc = 1'b0;
        phase_d = phase_q + 2'd1;
        bc_d    = bc_q;
        if (phase_q == 2'd3)
            bc_d = (bc_q == BC_LAST) ? 12'd0 : bc_q + 12'd1;

        unique case (state_q)
            S_CHECK, S_LOCKED: begin
                if (bus.bx0 && !slot) begin
                    // bx0 cycle becomes phase 0 of bc 0
                    phase_d = 2'd1;
                    bc_d    = 12'd0;
                    lock_d  = '0;
                    state_d = S_CHECK;
                    err_inc = 1'b1;
                end else if (slot && !bus.bx0) begin
                    lock_d  = '0;
                    state_d = S_HUNT;
                    err_inc = 1'b1;
                end else if (slot && state_q == S_CHECK) begin
                    lock_d = lock_inc;
                    if (lock_inc == LOCKN)
                        state_d = S_LOCKED;
                end
            end
            default: begin
                state_d = S_HUNT;
                if (bus.bx0) begin
                    phase_d = 2'd1;
                    bc_d    = 12'd0;
                    lock_d  = '0;
                    state_d = S_CHECK;
                end
            end
        endcase
    end

    // Word 0 goes straight out; words 1..3 shift out of frame_q.
    always_comb begin
        frame_d = frame_q;
        left_d  = left_q;
        txd_d   = txd_q;
        txv_d   = 1'b0;
        fs_d    = 1'b0;
        if (load) begin
            frame_d = bus.clusters_in[111:28];
            txd_d   = bus.clusters_in[27:0];
            txv_d   = 1'b1;
            fs_d    = 1'b1;
            left_d  = 2'd3;
        end else if (left_q != 2'd0) begin
            txd_d   = frame_q[27:0];
            frame_d = {28'd0, frame_q[83:28]};
            txv_d   = 1'b1;
            left_d  = left_q - 2'd1;
        end
`ifdef CLUSTER_TX_IDLE_SUPPRESS_EN
        if (txv_d && idle_word(txd_d))
            txv_d = 1'b0;
`endif
    end

    always_ff @(posedge clock4x or negedge reset) begin
        if (!reset) begin
            state_q  <= S_HUNT;
            lock_q   <= '0;
            phase_q  <= 2'd0;
            bc_q     <= 12'd0;
            locked_q <= 1'b0;
            serr_q   <= 8'd0;
            drop_q   <= 8'd0;
            frame_q  <= '0;
            left_q   <= 2'd0;
            txd_q    <= 28'd0;
            txv_q    <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            phase_q  <= phase_d;
            bc_q     <= bc_d;
            locked_q <= (state_d == S_LOCKED);
            if (err_inc && serr_q != 8'hFF)
                serr_q <= serr_q + 8'd1;
            if (bus.cluster_vld && !load && drop_q != 8'hFF)
                drop_q <= drop_q + 8'd1;
            frame_q  <= frame_d;
            left_q   <= left_d;
            txd_q    <= txd_d;
            txv_q    <= txv_d;
            fs_q     <= fs_d;
        end
    end

    assign bus.phase          = phase_q;
    assign bus.bc             = bc_q;
    assign bus.locked         = locked_q;
    assign bus.tx_data        = txd_q;
    assign bus.tx_valid       = txv_q;
    assign bus.tx_frame_start = fs_q;
    assign bus.sync_err_cnt   = serr_q;
    assign bus.drop_cnt       = drop_q;
endmodule

// File: tb/tb_cluster_tx_scheduler.sv
// Bench for cluster_tx_scheduler: directed phases with random data,
// checked every cycle against a timeline-based reference model.
`timescale 1ns/1ps
module tb_cluster_tx_scheduler;
    localparam int          MXBX     = 8;
    localparam int          LOCK_CNT = 2;
    localparam logic [10:0] INV      = 11'h7FE;

    typedef struct {
        logic        v;
        logic        fs;
        logic [27:0] d;
    } txw_t;

    logic clock4x = 1'b0;
    logic reset   = 1'b0;

    cluster_tx_scheduler_if bus ();

    cluster_tx_scheduler #(
        .MXBX(MXBX), .LOCK_CNT(LOCK_CNT), .INVALID_ADR(INV)
    ) dut (
        .clock4x(clock4x),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock4x = ~clock4x;

    int n_pass  = 0;
    int n_total = 0;

    // Model: phase/bc derive from the cycle of the last alignment (anchor).
    int t      = 0;
    int anchor = 0;
    int mode   = 0;   // 0 hunting, 1 checking, 2 locked
    int goods  = 0;
    int serr   = 0;
    int drops  = 0;
    txw_t txq[$];
    logic [27:0] e_d  = 28'd0;
    logic        e_v  = 1'b0;
    logic        e_fs = 1'b0;

    function automatic int m_phase();
        return (t - anchor) % 4;
    endfunction

    function automatic int m_bc();
        return ((t - anchor) / 4) % MXBX;
    endfunction

    function automatic bit m_slot();
        return m_phase() == 0 && m_bc() == 0;
    endfunction

    function automatic logic m_wvalid(input logic [27:0] w);
`ifdef CLUSTER_TX_IDLE_SUPPRESS_EN
        return !(w[10:0] == INV && w[24:14] == INV);
`else
        return (w === w);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s t=%0d observed=%0h expected=%0h",
                    tag, t, obs, exp);
    endtask

    task automatic check_all();
        chk("phase", 32'(bus.phase), 32'(m_phase()));
        chk("bc", 32'(bus.bc), 32'(m_bc()));
        chk("locked", 32'(bus.locked), 32'(mode == 2));
        chk("tx_valid", 32'(bus.tx_valid), 32'(e_v));
        chk("tx_fs", 32'(bus.tx_frame_start), 32'(e_fs));
        chk("tx_data", 32'(bus.tx_data), 32'(e_d));
        chk("sync_err", 32'(bus.sync_err_cnt), 32'(serr));
        chk("drop_cnt", 32'(bus.drop_cnt), 32'(drops));
    endtask

    task automatic step(input logic b, input logic v,
                        input logic [111:0] c);
        bit   slot, ld;
        txw_t w;
        slot = m_slot();
        ld   = v && mode == 2 && m_phase() == 3;
        if (v && !ld && drops < 255)
            drops++;
        if (ld) begin
            for (int p = 0; p < 4; p++) begin
                w.d  = c[28*p +: 28];
                w.v  = m_wvalid(w.d);
                w.fs = (p == 0);
                txq.push_back(w);
            end
        end
        if (mode == 0) begin
            if (b) begin
                anchor = t; mode = 1; goods = 0;
            end
        end else if (b && !slot) begin
            anchor = t; mode = 1; goods = 0;
            if (serr < 255) serr++;
        end else if (!b && slot) begin
            mode = 0;
            if (serr < 255) serr++;
        end else if (b && mode == 1) begin
            goods++;
            if (goods == LOCK_CNT) mode = 2;
        end
        t++;
        if (txq.size() > 0) begin
            w = txq.pop_front();
            e_v = w.v; e_fs = w.fs; e_d = w.d;
        end else begin
            e_v = 1'b0; e_fs = 1'b0;
        end
        bus.bx0         = b;
        bus.cluster_vld = v;
        bus.clusters_in = c;
        @(posedge clock4x);
        #1;
        bus.bx0         = 1'b0;
        bus.cluster_vld = 1'b0;
        check_all();
    endtask

    task automatic sstep(input logic v, input logic [111:0] c);
        step(m_slot(), v, c);
    endtask

    task automatic adv(input int ph, input bit need_lock);
        int k;
        k = 0;
        while (!(m_phase() == ph && (!need_lock || mode == 2)) && k < 300) begin
            sstep(1'b0, '0);
            k++;
        end
        if (k >= 300) begin
            n_total++;
            $error("FAIL adv_timeout t=%0d observed=%0d expected<300", t, k);
        end
    endtask

    function automatic logic [111:0] rnd_clusters();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[111:0];
    endfunction

    initial begin
        logic [111:0] c;
        int           d0, nv;
        bus.bx0         = 1'b0;
        bus.cluster_vld = 1'b0;
        bus.clusters_in = '0;

        // Reset state
        repeat (3) @(posedge clock4x);
        #1;
        chk("rst_phase", 32'(bus.phase), 0);
        chk("rst_bc", 32'(bus.bc), 0);
        chk("rst_locked", 32'(bus.locked), 0);
        chk("rst_txv", 32'(bus.tx_valid), 0);
        chk("rst_fs", 32'(bus.tx_frame_start), 0);
        chk("rst_txd", 32'(bus.tx_data), 0);
        chk("rst_serr", 32'(bus.sync_err_cnt), 0);
        chk("rst_drop", 32'(bus.drop_cnt), 0);
        reset = 1'b1;

        // 1. Lock-up: bx0 at cycle 5, then every 32 cycles
        while (t < 80) begin
            step((t >= 5) && ((t - 5) % 32 == 0), 1'b0, '0);
            if (t == 6) begin
                chk("p1_phase", 32'(bus.phase), 1);
                chk("p1_bc", 32'(bus.bc), 0);
            end
            if (t == 69) chk("p1_not_locked", 32'(bus.locked), 0);
            if (t == 70) chk("p1_locked", 32'(bus.locked), 1);
        end
        chk("p1_serr", 32'(bus.sync_err_cnt), 0);

        // 2. Frame serialisation
        adv(3, 1'b1);
        for (int k = 0; k < 8; k++)
            c[14*k +: 14] = {3'd1, 11'(10 + k)};
        sstep(1'b1, c);
        for (int i = 0; i < 4; i++) begin
            chk("p2_data", 32'(bus.tx_data),
                32'({3'd1, 11'(11 + 2*i), 3'd1, 11'(10 + 2*i)}));
            chk("p2_valid", 32'(bus.tx_valid), 1);
            chk("p2_fs", 32'(bus.tx_frame_start), 32'(i == 0));
            sstep(1'b0, '0);
        end
        for (int i = 0; i < 80; i++)
            sstep(($urandom % 3) == 0, rnd_clusters());

        // 3. Misaligned bx0 at phase 2
        adv(2, 1'b1);
        step(1'b1, 1'b0, '0);
        chk("p3_locked", 32'(bus.locked), 0);
        chk("p3_phase", 32'(bus.phase), 1);
        chk("p3_bc", 32'(bus.bc), 0);
        chk("p3_serr", 32'(bus.sync_err_cnt), 1);
        repeat (80) sstep(1'b0, '0);
        chk("p3_relock", 32'(bus.locked), 1);

        // 4. Missing bx0
        adv(0, 1'b1);
        while (!m_slot()) sstep(1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk("p4_locked", 32'(bus.locked), 0);
        chk("p4_serr", 32'(bus.sync_err_cnt), 2);
        d0 = drops;
        nv = 0;
        for (int i = 0; i < 24; i++) begin
            logic v;
            v = ($urandom % 2) == 1;
            if (v) nv++;
            step(1'b0, v, rnd_clusters());
            chk("p4_no_tx", 32'(bus.tx_valid), 0);
        end
        chk("p4_drops", 32'(bus.drop_cnt), 32'((d0 + nv > 255) ? 255 : d0 + nv));
        repeat (100) sstep(1'b0, '0);
        chk("p4_relock", 32'(bus.locked), 1);

        // Mixed random traffic with occasional bad bx0
        for (int i = 0; i < 300; i++)
            step(m_slot() ^ (($urandom % 40) == 0),
                 ($urandom % 4) == 0, rnd_clusters());
        repeat (100) sstep(1'b0, '0);

        // 5. Wrong-phase strobes
        for (int i = 0; i < 300; i++) begin
            adv(1, 1'b0);
            sstep(1'b1, rnd_clusters());
            chk("p5_no_tx", 32'(bus.tx_valid), 0);
        end
        chk("p5_drop_sat", 32'(bus.drop_cnt), 255);

        // 6. Idle word suppression
        repeat (70) sstep(1'b0, '0);
        adv(3, 1'b1);
        for (int k = 0; k < 8; k++)
            c[14*k +: 14] = (k < 2) ? {3'd0, INV} : {3'd1, 11'(20 + k)};
        sstep(1'b1, c);
`ifdef CLUSTER_TX_IDLE_SUPPRESS_EN
        chk("p6_w0_valid", 32'(bus.tx_valid), 0);
`else
        chk("p6_w0_valid", 32'(bus.tx_valid), 1);
`endif
        chk("p6_w0_fs", 32'(bus.tx_frame_start), 1);
        for (int i = 1; i < 4; i++) begin
            sstep(1'b0, '0);
            chk("p6_wn_valid", 32'(bus.tx_valid), 1);
            chk("p6_wn_fs", 32'(bus.tx_frame_start), 0);
        end
        repeat (4) sstep(1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cluster_tx_scheduler.md
Name: cluster_tx_scheduler

Overview:
- Sequences the cluster packer output onto the trigger link.
- Replaces the free-running 2-bit byte counter with a phase counter aligned to the TTC bx0 marker, and keeps a bunch counter.
- Tracks phase/bc lock with a sync FSM.
- Serialises each bunch crossing's 8 clusters as 4 words of 2 clusters, one word per clock4x cycle.

Parameters:
- MXBX, 3564: bunch crossings per orbit; bc wraps MXBX-1 -> 0.
- LOCK_CNT, 2: consecutive correctly-timed bx0 needed to go CHECK -> LOCKED.
- INVALID_ADR, 11'h7FE: cluster address value that marks an empty cluster.

Ports:
- clock4x  in  1  4x LHC clock; only clock.
- reset  in  1  asynchronous, active-low reset.
- bx0  in  1  TTC orbit marker, one clock4x wide, synchronous to clock4x.
- cluster_vld  in  1  packer output strobe, one cycle per bx.
- clusters_in  in  112  cluster k = bits [14k+13:14k], {size[2:0], adr[10:0]}.
- phase  out  2  bx phase; 0..3 = w0..w3 capture slots for the packer front end.
- bc  out  12  bunch counter.
- locked  out  1  FSM in LOCKED.
- tx_data  out  28  {cluster[2p+1], cluster[2p]} for word p.
- tx_valid  out  1  tx_data carries frame word.
- tx_frame_start  out  1  high with word 0.
- sync_err_cnt  out  8  saturating misaligned/missing bx0 count.
- drop_cnt  out  8  saturating dropped cluster_vld count.

Behaviour:
Reset (reset=0):
- state HUNT.
- phase, bc, tx_data, tx_valid, tx_frame_start, locked, lock counter, both error counters all 0.

Counters:
- phase increments by 1 every cycle, wrapping 3 -> 0.
- bc increments when phase 3 -> 0, wrapping MXBX-1 -> 0.

Expected bx0 slot: cycle with phase==0 and bc==0.

FSM:
- HUNT:
  - On bx0 at cycle t: phase=1 and bc=0 at t+1 (bx0 cycle defines phase 0); lock counter=0; -> CHECK.
  - No error counting in HUNT.
- CHECK:
  - bx0 in expected slot: lock counter++.
  - Lock counter reaches LOCK_CNT: -> LOCKED, locked=1 next cycle.
- CHECK or LOCKED, error cases:
  - bx0 outside expected slot: realign exactly as in HUNT, -> CHECK, sync_err_cnt++.
  - Expected slot with no bx0: -> HUNT, sync_err_cnt++.
  - locked drops the next cycle.

Frame load:
- Load condition: cluster_vld && state==LOCKED && phase==3. Registers all 8 clusters.
- cluster_vld in any other case: data ignored, drop_cnt++.
- Load at cycle t: words 0..3 appear on tx_data at t+1..t+4 (phase 0..3).
  - tx_frame_start=1 with word 0 only.
  - tx_valid=1 for all four words.
- Bx with no load: tx_valid=0, tx_frame_start=0, tx_data holds last value.
- Leaving LOCKED mid-frame: remaining words of that frame still go out; no further loads.

Counters and simultaneous events:
- sync_err_cnt and drop_cnt saturate at 255.
- Simultaneous bx0 error and cluster_vld: the load uses the pre-realign phase/state.

All outputs are registered.

Optional Feature:
- Macro: CLUSTER_TX_IDLE_SUPPRESS_EN.
- Defined:
  - A frame word whose two clusters both have adr==INVALID_ADR is sent with tx_valid=0.
  - tx_frame_start still marks word 0, even if that word is suppressed.
- Undefined: all four words of a loaded frame have tx_valid=1.

Test Plan (MXBX=8, LOCK_CNT=2):
1. Lock-up:
   - Stimulus: release reset; bx0 at cycle 5, then every 32 cycles.
   - Required: phase=1, bc=0 at cycle 6; CHECK; locked=1 the cycle after the 2nd on-time bx0; sync_err_cnt=0.
2. Frame serialisation:
   - Stimulus: while locked, cluster_vld at phase 3 with cluster k = {3'd1, 11'd(10+k)}.
   - Required: next 4 cycles tx_data = {1,11}/{1,10}, {1,13}/{1,12}, {1,15}/{1,14}, {1,17}/{1,16}; tx_valid=1 throughout; tx_frame_start only on the first.
3. Misaligned bx0:
   - Stimulus: while locked, bx0 arrives with phase==2.
   - Required: locked falls; phase=1, bc=0 next cycle; sync_err_cnt=1; relocks after 2 good bx0.
4. Missing bx0:
   - Stimulus: while locked, omit bx0 at the expected slot.
   - Required: HUNT; sync_err_cnt++; no loads until relock; each cluster_vld during that time increments drop_cnt.
5. Wrong-phase strobe:
   - Stimulus: cluster_vld at phase 1, repeated 300 times.
   - Required: no tx_valid; drop_cnt saturates at 255.
6. Idle suppress:
   - Stimulus: frame with clusters 0,1 = 0x7FE and rest valid; run with and without CLUSTER_TX_IDLE_SUPPRESS_EN.
   - Required, defined: word 0 has tx_valid=0, tx_frame_start=1.
   - Required, undefined: all 4 words valid.
